mem_port_arbiter: RTL and testbench

- Shares one synchronous-read, byte-write-enable RAM port between two requesters: instruction fetch (port I) and the MEM-stage load/store path (port D).
- Sits between the IF/MEM stages and a single unified memory.
- Issues at most one access per cycle and returns an ack one cycle after issue, matching the one-cycle RAM read latency.
- The MEM stage uses the D ack to raise its completion signal.

---
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port (I), the load/store port (D) and the shared RAM port
// of mem_port_arbiter.
//   slave  : the arbiter's view (takes requests and ram_rdata, drives acks
//            and the RAM strobe/address/enables/data)
//   master : the environment's view (requesters plus the RAM itself)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  // Fetch port
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_ack;
  logic [DATA_W-1:0] inst_rdata;

  // Load/store port
  logic              data_req;
  logic [ADDR_W-1:0] data_addr;
  logic [BE_W-1:0]   data_wen;
  logic [DATA_W-1:0] data_wdata;
  logic              data_ack;
  logic [DATA_W-1:0] data_rdata;

  // Shared RAM port
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [BE_W-1:0]   ram_wen;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_addr, data_wen, data_wdata,
    input  ram_rdata,
    output inst_ack, inst_rdata,
    output data_ack, data_rdata,
    output ram_en, ram_addr, ram_wen, ram_wdata
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_addr, data_wen, data_wdata,
    output ram_rdata,
    input  inst_ack, inst_rdata,
    input  data_ack, data_rdata,
    input  ram_en, ram_addr, ram_wen, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one synchronous-read, byte-write-enable RAM port between instruction
// fetch (I) and the MEM-stage load/store path (D). At most one access issues
// per cycle (combinationally, in the grant cycle); the ack follows one cycle
// later, aligned with the RAM read latency. D has fixed priority, and the port
// issued last cycle is masked so a still-high req is never issued twice and
// neither port can starve the other.
//
// Ports:
//   clk     : clock, all state on rising edge
//   resetn  : synchronous active-low reset
//   bus     : mem_port_arbiter_if.slave (I port, D port, RAM port)
//   perf_*  : 32-bit saturating grant/conflict counters (MEM_ARB_PERF_EN only)
//
// Optional feature: define MEM_ARB_PERF_EN to add the performance counters.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  mem_port_arbiter_if.slave     bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_inst_grants,
  output logic [31:0]           perf_data_grants,
  output logic [31:0]           perf_conflicts
`endif
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } owner_t;

  owner_t            r_owner;
  owner_t            w_owner_nxt;

  logic              w_elig_i;
  logic              w_elig_d;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_inst_ack;
  logic              w_data_ack;
  logic              w_ram_en;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [BE_W-1:0]   w_ram_wen;
  logic [DATA_W-1:0] w_ram_wdata;

  // Owner register: which port was issued in the previous cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_owner <= IDLE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // Eligibility, fixed-priority grant, RAM issue and acks.
  // Everything is gated by resetn so a reset cycle issues nothing and drops
  // the ack of any access that was in flight.
  always_comb begin
    w_owner_nxt = IDLE;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_ram_en    = 1'b0;
    w_ram_addr  = bus.data_addr;
    w_ram_wen   = '0;
    w_ram_wdata = bus.data_wdata;

    w_elig_i   = resetn && bus.inst_req && (r_owner != BUSY_I);
    w_elig_d   = resetn && bus.data_req && (r_owner != BUSY_D);
    w_inst_ack = resetn && (r_owner == BUSY_I);
    w_data_ack = resetn && (r_owner == BUSY_D);

    if (w_elig_d) begin
      w_grant_d   = 1'b1;
      w_owner_nxt = BUSY_D;
      w_ram_en    = 1'b1;
      w_ram_addr  = bus.data_addr;
      w_ram_wen   = bus.data_wen;
    end else if (w_elig_i) begin
      w_grant_i   = 1'b1;
      w_owner_nxt = BUSY_I;
      w_ram_en    = 1'b1;
      w_ram_addr  = bus.inst_addr;
      w_ram_wen   = '0;
    end
  end

  assign bus.ram_en     = w_ram_en;
  assign bus.ram_addr   = w_ram_addr;
  assign bus.ram_wen    = w_ram_wen;
  assign bus.ram_wdata  = w_ram_wdata;
  assign bus.inst_ack   = w_inst_ack;
  assign bus.data_ack   = w_data_ack;
  // Read data passes straight through; only meaningful alongside the ack
  assign bus.inst_rdata = bus.ram_rdata;
  assign bus.data_rdata = bus.ram_rdata;

`ifdef MEM_ARB_PERF_EN
  localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

  logic [31:0] r_perf_inst;
  logic [31:0] r_perf_data;
  logic [31:0] r_perf_conf;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_perf_inst <= '0;
      r_perf_data <= '0;
      r_perf_conf <= '0;
    end else begin
      if (w_grant_i && (r_perf_inst != PERF_MAX)) begin
        r_perf_inst <= r_perf_inst + 32'd1;
      end
      if (w_grant_d && (r_perf_data != PERF_MAX)) begin
        r_perf_data <= r_perf_data + 32'd1;
      end
      if (w_elig_i && w_elig_d && (r_perf_conf != PERF_MAX)) begin
        r_perf_conf <= r_perf_conf + 32'd1;
      end
    end
  end

  assign perf_inst_grants = r_perf_inst;
  assign perf_data_grants = r_perf_data;
  assign perf_conflicts   = r_perf_conf;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a small behavioural RAM
// (256 words, one-cycle read latency, byte write enables). Inputs change 1ns
// after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_inst_grants;
  logic [31:0] perf_data_grants;
  logic [31:0] perf_conflicts;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .bus              (bus.slave)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_inst_grants (perf_inst_grants),
    .perf_data_grants (perf_data_grants),
    .perf_conflicts   (perf_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial RAM contents: word index in byte 2
  function automatic logic [31:0] word_init(input int idx);
    return {8'hC0, 8'(idx), 16'h1234};
  endfunction

  logic [31:0] mem [0:255];

  // Behavioural RAM: read-before-write, data valid the cycle after ram_en
  always @(posedge clk) begin
    if (bus.ram_en) begin
      bus.ram_rdata <= mem[bus.ram_addr[9:2]];
      for (int b = 0; b < 4; b++) begin
        if (bus.ram_wen[b]) mem[bus.ram_addr[9:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int acks_i;
  int acks_d;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 256; i++) mem[i] = word_init(i);
    bus.ram_rdata  = '0;
    bus.inst_req   = 1'b0;
    bus.inst_addr  = '0;
    bus.data_req   = 1'b0;
    bus.data_addr  = '0;
    bus.data_wen   = '0;
    bus.data_wdata = '0;

    // Reset with a pending store: nothing may reach the RAM
    resetn        = 1'b0;
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h80;
    bus.data_wen  = 4'hF;
    @(negedge clk);
    check("rst_ram_en",   32'(bus.ram_en),   32'd0);
    check("rst_ram_wen",  32'(bus.ram_wen),  32'd0);
    check("rst_inst_ack", 32'(bus.inst_ack), 32'd0);
    check("rst_data_ack", 32'(bus.data_ack), 32'd0);
    next_cycle();
    bus.data_req = 1'b0;
    bus.data_wen = '0;
    resetn       = 1'b1;
    @(negedge clk);
    check("idle_ram_en",   32'(bus.ram_en),   32'd0);
    check("idle_inst_ack", 32'(bus.inst_ack), 32'd0);
    check("idle_data_ack", 32'(bus.data_ack), 32'd0);

    // Single fetch
    next_cycle();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h100;
    @(negedge clk);
    check("fetch_ram_en",   32'(bus.ram_en),   32'd1);
    check("fetch_ram_addr", bus.ram_addr,      32'h100);
    check("fetch_ram_wen",  32'(bus.ram_wen),  32'd0);
    check("fetch_ack_c0",   32'(bus.inst_ack), 32'd0);
    next_cycle();
    @(negedge clk);
    check("fetch_ack_c1",   32'(bus.inst_ack), 32'd1);
    check("fetch_rdata",    bus.inst_rdata,    32'hC0401234);
    check("fetch_no_reissue", 32'(bus.ram_en), 32'd0);
    next_cycle();
    bus.inst_req = 1'b0;
    @(negedge clk);
    check("fetch_ack_c2", 32'(bus.inst_ack), 32'd0);

    // Store one byte, then read the word back
    next_cycle();
    bus.data_req   = 1'b1;
    bus.data_addr  = 32'h201;
    bus.data_wen   = 4'b0010;
    bus.data_wdata = 32'h0000AB00;
    @(negedge clk);
    check("st_ram_en",    32'(bus.ram_en),  32'd1);
    check("st_ram_addr",  bus.ram_addr,     32'h201);
    check("st_ram_wen",   32'(bus.ram_wen), 32'h2);
    check("st_ram_wdata", bus.ram_wdata,    32'h0000AB00);
    next_cycle();
    @(negedge clk);
    check("st_ack",      32'(bus.data_ack), 32'd1);
    check("st_no_reissue", 32'(bus.ram_en), 32'd0);
    next_cycle();
    bus.data_addr = 32'h200;
    bus.data_wen  = 4'b0000;
    @(negedge clk);
    check("ld_ram_en",  32'(bus.ram_en),  32'd1);
    check("ld_ram_wen", 32'(bus.ram_wen), 32'd0);
    next_cycle();
    @(negedge clk);
    check("ld_ack",   32'(bus.data_ack), 32'd1);
    check("ld_rdata", bus.data_rdata,    32'hC080AB34);

    // Continuous requests on both ports for 10 cycles
    next_cycle();
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h80;
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h40;
    acks_i = 0;
    acks_d = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("cont_en_%0d", k),   32'(bus.ram_en), 32'd1);
      check($sformatf("cont_addr_%0d", k), bus.ram_addr, (k % 2 == 0) ? 32'h80 : 32'h40);
      acks_i += int'(bus.inst_ack);
      acks_d += int'(bus.data_ack);
      next_cycle();
    end
    bus.data_req = 1'b0;
    bus.inst_req = 1'b0;
    @(negedge clk);
    acks_i += int'(bus.inst_ack);
    acks_d += int'(bus.data_ack);
    check("cont_tail_en", 32'(bus.ram_en), 32'd0);
    check("cont_acks_i",  32'(acks_i),     32'd5);
    check("cont_acks_d",  32'(acks_d),     32'd5);

    // Clean reset, then simultaneous requests
    next_cycle();
    resetn = 1'b0;
    next_cycle();
    resetn        = 1'b1;
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h40;
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h80;
    @(negedge clk);
    check("sim_c0_addr",  bus.ram_addr,      32'h80);
    check("sim_c0_en",    32'(bus.ram_en),   32'd1);
    check("sim_c0_iack",  32'(bus.inst_ack), 32'd0);
    check("sim_c0_dack",  32'(bus.data_ack), 32'd0);
    next_cycle();
    @(negedge clk);
    check("sim_c1_dack",  32'(bus.data_ack), 32'd1);
    check("sim_c1_drd",   bus.data_rdata,    32'hC0201234);
    check("sim_c1_en",    32'(bus.ram_en),   32'd1);
    check("sim_c1_addr",  bus.ram_addr,      32'h40);
    check("sim_c1_wen",   32'(bus.ram_wen),  32'd0);
    check("sim_c1_iack",  32'(bus.inst_ack), 32'd0);
    next_cycle();
    bus.data_req = 1'b0;
    @(negedge clk);
    check("sim_c2_iack",  32'(bus.inst_ack), 32'd1);
    check("sim_c2_ird",   bus.inst_rdata,    32'hC0101234);
    check("sim_c2_dack",  32'(bus.data_ack), 32'd0);
    check("sim_c2_en",    32'(bus.ram_en),   32'd0);
    next_cycle();
    bus.inst_req = 1'b0;
    @(negedge clk);
`ifdef MEM_ARB_PERF_EN
    check("perf_conflicts",   perf_conflicts,   32'd1);
    check("perf_data_grants", perf_data_grants, 32'd1);
    check("perf_inst_grants", perf_inst_grants, 32'd1);
`endif

    // Reset in the cycle after a D read issues: the ack is dropped
    next_cycle();
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h84;
    @(negedge clk);
    check("rmid_issue_en", 32'(bus.ram_en), 32'd1);
    next_cycle();
    resetn = 1'b0;
    @(negedge clk);
    check("rmid_no_ack", 32'(bus.data_ack), 32'd0);
    check("rmid_no_en",  32'(bus.ram_en),   32'd0);
    next_cycle();
    resetn       = 1'b1;
    bus.data_req = 1'b0;
    @(negedge clk);
    check("rmid_idle_dack", 32'(bus.data_ack), 32'd0);
    check("rmid_idle_iack", 32'(bus.inst_ack), 32'd0);
    next_cycle();
    bus.data_req = 1'b1;
    @(negedge clk);
    check("rmid_reissue_en",   32'(bus.ram_en), 32'd1);
    check("rmid_reissue_addr", bus.ram_addr,    32'h84);
    next_cycle();
    @(negedge clk);
    check("rmid_ack",   32'(bus.data_ack), 32'd1);
    check("rmid_rdata", bus.data_rdata,    32'hC0211234);
    next_cycle();
    bus.data_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
